// File: rtl/thresholding_cfg_loader.sv
// Configuration initiator for the thresholding block: maps a channel-major threshold stream onto cfg_* writes.
// Optional readback/compare path is built when THRESH_LOADER_VERIFY_EN is defined.
module thresholding_cfg_loader #(
    parameter int unsigned N         = 2,
    parameter int unsigned K         = 8,
    parameter int unsigned C         = 4,
    parameter int unsigned PE        = 2,
    parameter int unsigned VFY_DEPTH = 8,
    localparam int unsigned CF       = C / PE,
    localparam int unsigned CFW      = $clog2(CF),
    localparam int unsigned PEW      = $clog2(PE),
    localparam int unsigned AW       = CFW + PEW + N
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          s_tvalid,
    output logic          s_tready,
    input  logic [K-1:0]  s_tdata,
    output logic          cfg_en,
    output logic          cfg_we,
    output logic [AW-1:0] cfg_a,
    output logic [K-1:0]  cfg_d,
    input  logic          cfg_rack,
    input  logic [K-1:0]  cfg_q,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [15:0]   err_cnt
);

    localparam int unsigned    CFS      = (CFW > 0) ? CFW : 1;
    localparam int unsigned    PES      = (PEW > 0) ? PEW : 1;
    localparam logic [N-1:0]   IDX_LAST = N'((2 ** N) - 2);
    localparam logic [PES-1:0] PE_LAST  = PES'(PE - 1);
    localparam logic [CFS-1:0] CF_LAST  = CFS'(CF - 1);

    generate
        if ((C % PE) != 0 || VFY_DEPTH == 0) begin : g_bad_cfg
            $error("thresholding_cfg_loader: C must be a multiple of PE and VFY_DEPTH must be nonzero");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   idx_q, idx_d;
    logic [PES-1:0] pe_q, pe_d;
    logic [CFS-1:0] cf_q, cf_d;
    logic           last_q, last_d;
    logic           s_tready_q, s_tready_d;
    logic           cfg_en_q, cfg_en_d;
    logic           cfg_we_q, cfg_we_d;
    logic [AW-1:0]  cfg_a_q, cfg_a_d;
    logic [K-1:0]   cfg_d_q, cfg_d_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic [15:0]    err_cnt_q, err_cnt_d;
    logic           accept;
    logic [AW-1:0]  addr;

`ifdef THRESH_LOADER_VERIFY_EN
    localparam int unsigned PTRW = (VFY_DEPTH > 1) ? $clog2(VFY_DEPTH) : 1;
    localparam int unsigned CNTW = $clog2(VFY_DEPTH + 1);
    logic [K-1:0]    fifo_mem [VFY_DEPTH];
    logic [PTRW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            push, pop, mismatch;
`else
    logic unused_rb;
    assign unused_rb = ^{cfg_rack, cfg_q};
`endif

    assign accept = s_tvalid && s_tready_q;
    // Fields concatenate as {cf, pe, idx}; zero-width fields shift out of AW.
    assign addr = AW'(idx_q) | (AW'(pe_q) << N) | (AW'(cf_q) << (PEW + N));

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pe_d      = pe_q;
        cf_d      = cf_q;
        last_d    = last_q;
        cfg_en_d  = 1'b0;
        cfg_we_d  = 1'b0;
        cfg_a_d   = cfg_a_q;
        cfg_d_d   = cfg_d_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
`ifdef THRESH_LOADER_VERIFY_EN
        push     = 1'b0;
        pop      = 1'b0;
        mismatch = 1'b0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        // Responses are matched in issue order; one arriving with nothing outstanding is itself an error.
        if (state_q != IDLE && cfg_rack) begin
            if (cnt_q == '0) begin
                mismatch = 1'b1;
            end else begin
                pop      = 1'b1;
                mismatch = (cfg_q != fifo_mem[rd_ptr_q]);
            end
        end
        if (mismatch) begin
            err_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 16'd1;
        end
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = LOAD;
                    idx_d     = '0;
                    pe_d      = '0;
                    cf_d      = '0;
                    last_d    = 1'b0;
                    err_d     = 1'b0;
                    err_cnt_d = '0;
                end
            end
            LOAD: begin
                if (accept) begin
                    cfg_en_d = 1'b1;
                    cfg_we_d = 1'b1;
                    cfg_a_d  = addr;
                    cfg_d_d  = s_tdata;
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
                        if (pe_q == PE_LAST) begin
                            pe_d = '0;
                            if (cf_q == CF_LAST) begin
                                cf_d   = '0;
                                last_d = 1'b1;
                            end else begin
                                cf_d = cf_q + CFS'(1);
                            end
                        end else begin
                            pe_d = pe_q + PES'(1);
                        end
                    end else begin
                        idx_d = idx_q + N'(1);
                    end
                end
`ifdef THRESH_LOADER_VERIFY_EN
                if (cfg_en_q && cfg_we_q) begin
                    cfg_en_d = 1'b1;
                    cfg_we_d = 1'b0;
                    push     = 1'b1;
                end
                if (cfg_en_q && !cfg_we_q && last_q) state_d = DRAIN;
`else
                if (cfg_en_q && last_q) state_d = DONE;
`endif
            end
`ifdef THRESH_LOADER_VERIFY_EN
            DRAIN: if (cnt_q == CNTW'(pop)) state_d = DONE;
`else
            DRAIN: state_d = IDLE;
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef THRESH_LOADER_VERIFY_EN
        if (push) wr_ptr_d = (wr_ptr_q == PTRW'(VFY_DEPTH - 1)) ? '0 : wr_ptr_q + PTRW'(1);
        if (pop)  rd_ptr_d = (rd_ptr_q == PTRW'(VFY_DEPTH - 1)) ? '0 : rd_ptr_q + PTRW'(1);
        cnt_d = cnt_q + CNTW'(push) - CNTW'(pop);
        // No accept directly after an accept: that slot is taken by the readback.
        s_tready_d = (state_d == LOAD) && !last_d && !accept && (cnt_d < CNTW'(VFY_DEPTH));
`else
        s_tready_d = (state_d == LOAD) && !last_d;
`endif
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            pe_q       <= '0;
            cf_q       <= '0;
            last_q     <= 1'b0;
            s_tready_q <= 1'b0;
            cfg_en_q   <= 1'b0;
            cfg_we_q   <= 1'b0;
            cfg_a_q    <= '0;
            cfg_d_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
`ifdef THRESH_LOADER_VERIFY_EN
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pe_q       <= pe_d;
            cf_q       <= cf_d;
            last_q     <= last_d;
            s_tready_q <= s_tready_d;
            cfg_en_q   <= cfg_en_d;
            cfg_we_q   <= cfg_we_d;
            cfg_a_q    <= cfg_a_d;
            cfg_d_q    <= cfg_d_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
`ifdef THRESH_LOADER_VERIFY_EN
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
`endif
        end
    end

`ifdef THRESH_LOADER_VERIFY_EN
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= cfg_d_q;
    end
`endif

    assign s_tready = s_tready_q;
    assign cfg_en   = cfg_en_q;
    assign cfg_we   = cfg_we_q;
    assign cfg_a    = cfg_a_q;
    assign cfg_d    = cfg_d_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: doc/thresholding_cfg_loader.md
# thresholding_cfg_loader

Configuration initiator for the binary-search thresholding block. Accepts a flat stream of threshold values, maps each to the channel/PE/threshold address layout of the thresholding configuration port, and issues the write cycles. Sits between a host DMA/stream source and the thresholding instance's `cfg_*` port. An optional in-line readback path compares each written value with the value read back.

## Interface
- `N`, none: output precision of the target; 2^N-1 thresholds per channel.
- `K`, none: threshold width.
- `C`, none: channel count; `C % PE == 0` is required and is checked at elaboration.
- `PE`, none: target parallelism.
- `VFY_DEPTH`, 8: depth of the expected-value FIFO (verify builds only).
- Derived `AW` = $clog2(C/PE) + $clog2(PE) + N. Zero-width fields are omitted.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  pulse that begins a load session; ignored while `busy`
- `s_tvalid`  in  1  threshold stream valid
- `s_tready`  out  1  threshold stream ready
- `s_tdata`  in  K  threshold value
- `cfg_en`  out  1  config cycle enable
- `cfg_we`  out  1  1 = write, 0 = readback
- `cfg_a`  out  AW  config address {cf, pe, idx}
- `cfg_d`  out  K  write data
- `cfg_rack`  in  1  readback data valid (single-cycle pulse)
- `cfg_q`  in  K  readback data
- `busy`  out  1  session in progress
- `done`  out  1  one-cycle pulse at session end
- `err`  out  1  sticky mismatch flag; cleared by `start`
- `err_cnt`  out  16  mismatch count, saturating at 0xFFFF; cleared by `start`

## Operation
- **Stream order:** channel-major. For c = 0..C-1, for i = 0..2^N-2 (ascending thresholds).
- **Address:** cf = c / PE, pe = c % PE, `cfg_a = {cf, pe, i}`. Index 2^N-1 is never issued.
- **Session length:** W = C·(2^N-1) words.
- **States:**
  - IDLE: on `start`, clear counters, `err` and `err_cnt`, go to LOAD.
  - LOAD: accept words. After the last word's final config cycle, go to DRAIN (verify build) or DONE.
  - DRAIN: wait until the expected FIFO is empty.
  - DONE: pulse `done` for one cycle, return to IDLE.
- **Counters:** idx wraps 2^N-2 → 0 and increments c. c wraps C-1 → 0 only at session end.
- `cfg_en` is high only on issued config cycles, never while idle, so the target's data path is blocked only during actual config cycles.

## Timing
- **Reset values:** all outputs 0 (`s_tready`, `cfg_en`, `cfg_we`, `cfg_a`, `cfg_d`, `busy`, `done`, `err`, `err_cnt`). State is IDLE and the FIFO is empty.
- **Write issue:** `cfg_*` outputs are registered. A beat accepted in cycle t produces a write (`cfg_en=1`, `cfg_we=1`) in cycle t+1.
- **`s_tready`:** high only in LOAD and only when the next issue slot is free. It never depends combinationally on `s_tvalid`.
- **`busy`:** high from the cycle after `start` through the `done` cycle inclusive.
- **Readback latency:** no fixed latency is assumed. Responses are matched strictly in order.
- **`cfg_rack` while IDLE:** ignored, not counted. This covers stale reads after a reset mid-session.
- **Reset mid-session:** aborts immediately. No `done` is pulsed. Partial writes remain in the target.
- **`start` while busy:** ignored.
- **`start` coinciding with DONE:** ignored. The next `start` is accepted in IDLE.

## Configuration
- Macro: `THRESH_LOADER_VERIFY_EN`.
- **Defined:**
  - Each write at t+1 is followed by a readback of the same address at t+2 (`cfg_en=1`, `cfg_we=0`).
  - The write data is pushed into the expected FIFO (`VFY_DEPTH` entries) when the readback is issued.
  - `s_tready` is high at most every other cycle, and low while the FIFO is full.
  - On each `cfg_rack`, pop the FIFO and compare `cfg_q` with the popped value. A mismatch sets `err` and increments `err_cnt`.
  - A `cfg_rack` with the FIFO empty outside IDLE also counts as a mismatch.
  - `done` follows DRAIN completion.
- **Undefined:**
  - Writes only, up to one per cycle; `s_tready` is high throughout LOAD.
  - No FIFO. `cfg_rack`/`cfg_q` are ignored; `err` and `err_cnt` stay 0.
  - `done` pulses the cycle after the last write.

## Test plan
All scenarios use N=2, K=8, C=4, PE=2.
- **Address map:** stream 12 values 10..21 with `s_tvalid` held high → writes in order to addresses 0,1,2,4,5,6,8,9,10,12,13,14 with `cfg_d` = 10..21; one `done`; `busy` low afterwards.
- **Throughput:** without the macro, 12 writes on 12 consecutive cycles. With the macro, strict WR/RB alternation over 24 cycles.
- **Backpressure/bubbles:** random `s_tvalid` gaps → the same 12 address/data pairs in order, and no `cfg_en` on idle cycles.
- **Verify:** a responder model with 4-cycle read latency that corrupts the readback at address 5 → `err`=1, `err_cnt`=1. A FIFO-full stall is observable with `VFY_DEPTH`=1 and latency 6.
- **Reset mid-load:** `rst` after 5 writes → all outputs 0 the next cycle. Late `cfg_rack` is ignored. A new `start` restarts at address 0 with `err_cnt`=0.
- **Start hygiene:** `start` pulsed during LOAD and in the DONE cycle → no restart. The next `start` in IDLE clears `err` from the previous session.
